conv_out_collector: RTL and testbench

//   Downstream stage of the DSP-cascade convolution PE. Captures each valid
//   48-bit PE result (i_P qualified by i_en = PE o_en), then:
//   - adds bias
//   - rounds and requantises to OUT_WIDTH, with optional ReLU
//   - tags raster position and end-of-frame
//   - buffers results in a FIFO with a valid/ready output toward the write-back stage.
//   The PE has no backpressure, so this block absorbs stalls and flags any loss.

---
 rtl/conv_out_collector.sv | 107 ++++++++++
 tb/tb_conv_out_collector.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/conv_out_collector.sv
// conv_out_collector: bias, round/requantise, ReLU, raster tag and FWFT buffering of PE results
module conv_out_collector #(
    parameter int KERNEL_SIZE = 2,
    parameter int FM_SIZE     = 4,
    parameter int OUT_WIDTH   = 16,
    parameter int FRAC_SHIFT  = 8,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_en,
    input  logic [47:0]                   i_P,
    input  logic [31:0]                   i_bias,
    input  logic                          i_relu_en,
    output logic [OUT_WIDTH-1:0]          o_data,
    output logic                          o_last,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic                          o_frame_done,
    output logic                          o_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);
    localparam int OUT_DIM = FM_SIZE - KERNEL_SIZE + 1;
    localparam int CW = OUT_DIM > 1 ? $clog2(OUT_DIM) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic signed [49:0] RND  = 50'sd1 <<< FRAC_SHIFT >>> 1;
    localparam logic signed [49:0] SMAX = (50'sd1 <<< (OUT_WIDTH - 1)) - 50'sd1;
    localparam logic signed [49:0] SMIN = -SMAX - 50'sd1;

    logic [CW-1:0] col, row;
    logic last_col, last_row;
    logic s1_valid, s1_relu, s1_last;
    logic [48:0] s1_sum;
    logic s2_valid, s2_last;
    logic [OUT_WIDTH-1:0] s2_data;
    logic signed [49:0] rnd, shf, rel;
    logic [OUT_WIDTH-1:0] sat;
    logic [OUT_WIDTH:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic full, pop, wr, drop;

    assign last_col = col == CW'(OUT_DIM - 1);
    assign last_row = row == CW'(OUT_DIM - 1);
    assign o_valid  = o_count != '0;
    assign o_data   = o_valid ? mem[rp][OUT_WIDTH-1:0] : '0;
    assign o_last   = o_valid & mem[rp][OUT_WIDTH];
    assign full     = o_count == (AW + 1)'(FIFO_DEPTH);
    assign pop      = o_valid & i_ready;
    assign wr       = s2_valid & (~full | pop);
    assign drop     = s2_valid & full & ~pop;

    // round half up, optional ReLU, then saturate to the signed output range
    always_comb begin
        rnd = {s1_sum[48], s1_sum} + RND;
        shf = rnd >>> FRAC_SHIFT;
        rel = (s1_relu && shf[49]) ? '0 : shf;
        sat = rel > SMAX ? OUT_WIDTH'(SMAX) : rel < SMIN ? OUT_WIDTH'(SMIN) : rel[OUT_WIDTH-1:0];
    end

    // pipeline valids and raster position; counters advance on every accepted input
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            col      <= '0;
            row      <= '0;
        end else begin
            s1_valid <= i_en;
            s2_valid <= s1_valid;
            if (i_en) begin
                col <= last_col ? '0 : col + CW'(1);
                row <= last_col ? (last_row ? '0 : row + CW'(1)) : row;
            end
        end
    end

    // pipeline data: bias add in stage 1, requantised result in stage 2
    always_ff @(posedge i_clk) begin
        s1_sum  <= {i_P[47], i_P} + {{17{i_bias[31]}}, i_bias};
        s1_relu <= i_relu_en;
        s1_last <= last_col & last_row;
        s2_data <= sat;
        s2_last <= s1_last;
    end

    // FIFO storage; a write while full only happens alongside a pop
    always_ff @(posedge i_clk) begin
        if (wr) mem[wp] <= {s2_last, s2_data};
    end

    // FIFO pointers, occupancy, sticky drop flag and end-of-frame pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wp           <= '0;
            rp           <= '0;
            o_count      <= '0;
            o_overflow   <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            if (wr) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            o_count      <= o_count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
            o_overflow   <= o_overflow | drop;
            o_frame_done <= pop & mem[rp][OUT_WIDTH];
        end
    end
endmodule

// File: tb/tb_conv_out_collector.sv
// tb_conv_out_collector: scoreboard bench with a behavioural model of the collector
module tb_conv_out_collector;
    localparam int FS    = 8;
    localparam int DEPTH = 8;
    localparam int NPIX  = 9;

    logic clk = 0, rst = 1, en = 0, relu = 0, rdy = 0;
    logic [47:0] p = '0;
    logic [31:0] bias = '0;
    logic [15:0] o_data;
    logic o_last, o_valid, o_frame_done, o_overflow;
    logic [3:0] o_count;

    always #5 clk = ~clk;

    conv_out_collector #(
        .KERNEL_SIZE(2), .FM_SIZE(4), .OUT_WIDTH(16), .FRAC_SHIFT(FS), .FIFO_DEPTH(DEPTH)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_P(p), .i_bias(bias), .i_relu_en(relu),
        .o_data(o_data), .o_last(o_last), .o_valid(o_valid), .i_ready(rdy),
        .o_frame_done(o_frame_done), .o_overflow(o_overflow), .o_count(o_count)
    );

    typedef struct {
        logic [15:0] d;
        logic        l;
    } ent_t;

    ent_t sb[$];
    ent_t d1, d2;
    bit d1v = 0, d2v = 0, ovf = 0, fd_exp = 0;
    int occ = 0, k = 0;
    int vectors = 0, miscompares = 0;

    function automatic logic [15:0] ref_val(logic [47:0] pp, logic [31:0] bb, bit rl);
        longint s, r;
        s = longint'($signed(pp)) + longint'($signed(bb));
        r = (s + (longint'(1) <<< (FS - 1))) >>> FS;
        if (rl && r < 0) r = 0;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return 16'(r);
    endfunction

    task automatic chk(string nm, longint act, longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: results arrive in the buffer two edges after capture
    always @(posedge clk) begin
        bit pop_m;
        if (rst) begin
            sb.delete();
            occ = 0; ovf = 0; d1v = 0; d2v = 0; k = 0;
        end else begin
            pop_m = occ > 0 && rdy;
            if (d2v) begin
                if (occ < DEPTH || pop_m) begin
                    sb.push_back(d2);
                    occ++;
                end else ovf = 1;
            end
            if (pop_m) occ--;
            d2 = d1; d2v = d1v;
            d1v = en;
            if (en) begin
                d1.d = ref_val(p, bias, relu);
                d1.l = (k == NPIX - 1);
                k = (k + 1) % NPIX;
            end
        end
    end

    // monitor: compare flags every cycle and the head entry whenever it is presented
    always @(negedge clk) begin
        chk("count", o_count, occ);
        chk("valid", o_valid, occ != 0);
        chk("overflow", o_overflow, ovf);
        chk("frame_done", o_frame_done, fd_exp);
        if (o_valid) begin
            if (sb.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL unexpected_valid: got data %0h expected no entry", o_data);
            end else begin
                chk("data", o_data, sb[0].d);
                chk("last", o_last, sb[0].l);
            end
        end else begin
            chk("idle_data", o_data, 0);
            chk("idle_last", o_last, 0);
        end
        fd_exp = !rst && o_valid && rdy && sb.size() > 0 && sb[0].l;
        if (o_valid && rdy && sb.size() > 0) void'(sb.pop_front());
    end

    task automatic cyc(bit e, logic [47:0] pp, logic [31:0] bb, bit rl, bit r);
        en = e; p = pp; bias = bb; relu = rl; rdy = r;
        @(posedge clk); #1;
    endtask

    task automatic idle(int n, bit r);
        repeat (n) cyc(0, '0, '0, 0, r);
    endtask

    task automatic do_reset();
        rst = 1;
        cyc(1, 48'h12345, 32'h0, 0, 1);
        rst = 0;
    endtask

    task automatic burst(int n, bit r);
        repeat (n) cyc(1, 48'($signed($urandom) >>> 10), 32'($signed($urandom) >>> 16), 1'($urandom), r);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0;
        cyc(1, 48'h180, 0, 0, 1);
        cyc(1, 48'h17F, 0, 0, 1);
        cyc(1, -48'sd384, 0, 0, 1);
        cyc(1, 48'h1000000, 0, 0, 1);
        cyc(1, -48'sd16777216, 0, 0, 1);
        cyc(1, -48'sd16777216, 0, 1, 1);
        cyc(1, 48'h0, 32'h100, 0, 1);
        cyc(1, 48'h0, 32'hFFFFFF80, 0, 1);
        cyc(1, 48'h7FFFFFFFFFFF, 32'h7FFFFFFF, 0, 1);
        idle(6, 1);
        do_reset();
        for (int i = 0; i < NPIX; i++) begin
            burst(1, 1);
            idle(1, 1);
        end
        burst(3, 1);
        idle(8, 1);
        do_reset();
        burst(DEPTH, 0);
        idle(2, 0);
        cyc(1, 48'h2500, 0, 0, 0);
        idle(1, 0);
        idle(1, 1);
        idle(3, 0);
        idle(12, 1);
        do_reset();
        burst(10, 0);
        idle(4, 0);
        idle(14, 1);
        do_reset();
        burst(4, 1);
        rst = 1;
        idle(1, 1);
        rst = 0;
        burst(NPIX, 1);
        idle(8, 1);
        do_reset();
        for (int i = 0; i < 500; i++) begin
            case ($urandom_range(0, 2))
                0: cyc(1'($urandom), {$urandom, $urandom}, $urandom, 1'($urandom), $urandom_range(0, 3) != 0);
                1: cyc(1'($urandom), 48'($signed($urandom) >>> 6), 32'($signed($urandom) >>> 12), 1'($urandom), $urandom_range(0, 3) != 0);
                default: cyc(1'($urandom), 48'($signed($urandom) >>> 14), 32'($signed($urandom) >>> 20), 1'($urandom), $urandom_range(0, 1) != 0);
            endcase
        end
        idle(20, 1);
        chk("drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
